// File: rtl/register_file_if.sv
// Register file port bundle: write port, three read ports and write statistics.
// master = the datapath driving indices/write data; slave = the register file.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] Write_Register;
  logic [DATA_WIDTH-1:0] Write_Data;
  logic [ADDR_WIDTH-1:0] Read_Register1;
  logic [ADDR_WIDTH-1:0] Read_Register2;
  logic [ADDR_WIDTH-1:0] Debug_Register;
  logic [DATA_WIDTH-1:0] Read_Data1;
  logic [DATA_WIDTH-1:0] Read_Data2;
  logic [DATA_WIDTH-1:0] Debug_Data;
  logic [31:0]           Write_Count;
  logic [ADDR_WIDTH-1:0] Last_Write_Register;

  modport master (
    output RegWrite, Write_Register, Write_Data,
    output Read_Register1, Read_Register2, Debug_Register,
    input  Read_Data1, Read_Data2, Debug_Data, Write_Count, Last_Write_Register
  );

  modport slave (
    input  RegWrite, Write_Register, Write_Data,
    input  Read_Register1, Read_Register2, Debug_Register,
    output Read_Data1, Read_Data2, Debug_Data, Write_Count, Last_Write_Register
  );
endinterface

// File: rtl/register_file.sv
// MIPS-style register file: 2**ADDR_WIDTH x DATA_WIDTH, r0 hardwired to zero,
// two combinational operand read ports plus a debug read port, one write port.
// Tracks committed writes (wrapping 32-bit count) and the last written index.
// Optional feature: define REGFILE_BYPASS_EN to forward Write_Data to any read
// port whose index matches the register being written in the same cycle.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic             clk,
  input logic             reset_n,
  register_file_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [31:0]           write_count;
  logic [ADDR_WIDTH-1:0] last_write_register;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  logic [DATA_WIDTH-1:0] rdd;

  // A write is real only out of reset, when enabled, and not aimed at r0.
  // An X on RegWrite makes this X, which the if below treats as "no write".
  assign commit = reset_n && bus.RegWrite && (bus.Write_Register != '0);

  // Register array and write statistics; everything clears asynchronously.
  // NOTE: the array is built from flops and must read 0 straight after reset,
  // so it is reset like any other state rather than left as an uninitialised RAM.
  // NOTE: non-blocking assignments keep same-edge readers seeing the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      write_count         <= '0;
      last_write_register <= '0;
    end else if (commit) begin
      regs[bus.Write_Register] <= bus.Write_Data;
      write_count              <= write_count + 32'd1;
      last_write_register      <= bus.Write_Register;
    end
  end

  // Read port 1: array lookup, optionally overridden by the in-flight write.
  // NOTE: the default assignment comes first so no path can infer a latch.
  always_comb begin
    rd1 = regs[bus.Read_Register1];
`ifdef REGFILE_BYPASS_EN
    if (commit && (bus.Read_Register1 == bus.Write_Register)) rd1 = bus.Write_Data;
`endif
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    rd2 = regs[bus.Read_Register2];
`ifdef REGFILE_BYPASS_EN
    if (commit && (bus.Read_Register2 == bus.Write_Register)) rd2 = bus.Write_Data;
`endif
  end

  // Debug read port: same structure as the operand ports.
  always_comb begin
    rdd = regs[bus.Debug_Register];
`ifdef REGFILE_BYPASS_EN
    if (commit && (bus.Debug_Register == bus.Write_Register)) rdd = bus.Write_Data;
`endif
  end

  assign bus.Read_Data1          = rd1;
  assign bus.Read_Data2          = rd2;
  assign bus.Debug_Data          = rdd;
  assign bus.Write_Count         = write_count;
  assign bus.Last_Write_Register = last_write_register;

  // Simulation-only guard: an unknown write enable at an active edge is a
  // datapath bug upstream; the array itself is left untouched in that case.
  a_regwrite_known: assert property (
    @(posedge clk) disable iff (!reset_n) !$isunknown(bus.RegWrite)
  );

endmodule
